// File: rtl/iob_master_seq.sv
// iob_master_seq: sequences CONO/DATAO/CONI/DATAI requests and bus resets onto the PDP-6 I/O bus master signals.
module iob_master_seq #(
  parameter int CLR_CYCLES = 2,
  parameter int SET_DELAY  = 1,
  parameter int SET_CYCLES = 2,
  parameter int RD_CYCLES  = 3,
  parameter int RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [6:0]  cmd_dev,
  input  logic [35:0] cmd_data,
  input  logic        bus_reset_req,
  output logic        rsp_valid,
  output logic [35:0] rsp_data,
  output logic        iob_poweron,
  output logic        iob_reset,
  output logic [6:0]  ios,
  output logic [35:0] iob_write,
  output logic        cono_clear,
  output logic        cono_set,
  output logic        datao_clear,
  output logic        datao_set,
  output logic        iob_fm_status,
  output logic        iob_fm_datai,
  input  logic [35:0] iob_read
);
  localparam logic [2:0] IDLE = 3'd0, CLR = 3'd1, GAP = 3'd2, SET = 3'd3, RD = 3'd4, RSP = 3'd5, BRST = 3'd6;
  logic [2:0] state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] op_q, op_n;
  logic accept, done;
  assign cmd_ready = reset & (state == IDLE) & ~bus_reset_req;
  assign accept = cmd_valid & cmd_ready;
  assign done = cnt == 4'd0;
  assign op_n = accept ? cmd_op : op_q;
  always_comb begin
    state_n = state;
    cnt_n = done ? cnt : cnt - 4'd1;
    case (state)
      IDLE: begin
        if (bus_reset_req) begin
          state_n = BRST;
          cnt_n = 4'(RST_CYCLES - 1);
        end else if (cmd_valid) begin
          state_n = cmd_op[1] ? RD : CLR;
          cnt_n = cmd_op[1] ? 4'(RD_CYCLES - 1) : 4'(CLR_CYCLES - 1);
        end
      end
      CLR: if (done) begin
        state_n = (SET_DELAY > 0) ? GAP : SET;
        cnt_n = (SET_DELAY > 0) ? 4'(SET_DELAY - 1) : 4'(SET_CYCLES - 1);
      end
      GAP: if (done) begin
        state_n = SET;
        cnt_n = 4'(SET_CYCLES - 1);
      end
      SET, RD: state_n = done ? RSP : state;
      RSP: state_n = IDLE;
      BRST: state_n = done ? IDLE : state;
      default: state_n = IDLE;
    endcase
  end
  // Bus outputs are decoded from the next state so each pulse starts on the edge that enters its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      iob_poweron <= 1'b0;
      iob_reset <= 1'b0;
      ios <= '0;
      iob_write <= '0;
      cono_clear <= 1'b0;
      cono_set <= 1'b0;
      datao_clear <= 1'b0;
      datao_set <= 1'b0;
      iob_fm_status <= 1'b0;
      iob_fm_datai <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      op_q <= op_n;
      iob_poweron <= 1'b1;
      rsp_valid <= state_n == RSP;
      iob_reset <= state_n == BRST;
      ios <= accept ? cmd_dev : (state_n == IDLE ? '0 : ios);
      iob_write <= accept ? (cmd_op[1] ? '0 : cmd_data) : (state_n == IDLE ? '0 : iob_write);
      cono_clear <= (state_n == CLR) & (op_n == 2'd0);
      datao_clear <= (state_n == CLR) & (op_n == 2'd1);
      cono_set <= (state_n == SET) & (op_n == 2'd0);
      datao_set <= (state_n == SET) & (op_n == 2'd1);
      iob_fm_status <= (state_n == RD) & (op_n == 2'd2);
      iob_fm_datai <= (state_n == RD) & (op_n == 2'd3);
      if (state == RD && done) rsp_data <= iob_read;
      else if (state == SET && done) rsp_data <= '0;
    end
  end
endmodule
